// File: rtl/axi_pkg.sv
// Shared definitions for the AXI read responder slice.
//   burst_e     : AXI burst encodings (FIXED/INCR/WRAP)
//   OKAY/SLVERR : read response codes
//   rsp_state_e : responder FSM states
package axi_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2
  } burst_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } rsp_state_e;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address and burst legality for an AXI read burst.
// Ports:
//   addr      in  64  current beat byte address
//   len       in  8   beats minus one
//   size      in  3   log2 bytes per beat
//   burst     in  2   burst type
//   next_addr out 64  address of the following beat
//   legal     out 1   burst parameters are serviceable
module axi_burst_addr_gen
  import axi_pkg::*;
(
  input  logic [63:0] addr,
  input  logic [7:0]  len,
  input  logic [2:0]  size,
  input  logic [1:0]  burst,
  output logic [63:0] next_addr,
  output logic        legal
);

  logic [63:0] bytes;
  logic [63:0] total;
  logic [2:0]  wrap_sh;
  logic        wrap_ok;

  always_comb begin
    bytes   = 64'd1 << size;
    wrap_ok = 1'b0;
    wrap_sh = 3'd0;
    case (len)
      8'd1:  begin wrap_ok = 1'b1; wrap_sh = 3'd1; end
      8'd3:  begin wrap_ok = 1'b1; wrap_sh = 3'd2; end
      8'd7:  begin wrap_ok = 1'b1; wrap_sh = 3'd3; end
      8'd15: begin wrap_ok = 1'b1; wrap_sh = 3'd4; end
      default: ;
    endcase
    // Wrap window is bytes*(len+1); len+1 is a power of two when legal.
    total = bytes << wrap_sh;

    next_addr = addr;
    case (burst)
      INCR:    next_addr = (addr & ~(bytes - 64'd1)) + bytes;
      WRAP:    next_addr = (addr & ~(total - 64'd1)) | ((addr + bytes) & (total - 64'd1));
      default: next_addr = addr;
    endcase

    legal = (size <= 3'd3) && (burst != 2'd3) && ((burst != WRAP) || wrap_ok);
  end

endmodule

// File: rtl/axi_rd_responder.sv
// AXI4 read-channel responder backed by a local 64-bit word memory.
// Serves one AR burst at a time, streams R beats under rready backpressure,
// flags illegal bursts and out-of-range beats with SLVERR. A side load port
// writes the memory at any time.
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   s_axi_ar*             read address channel (slave side)
//   s_axi_r*              read data channel (slave side)
//   load_we/addr/data     memory preload port
//   busy                  burst in progress
module axi_rd_responder
  import axi_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR      = 64'h0,
  parameter int unsigned MEM_WORDS      = 1024,
  parameter int unsigned FIRST_BEAT_LAT = 2,
  localparam int unsigned AW            = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [63:0]   s_axi_araddr,
  input  logic [7:0]    s_axi_arlen,
  input  logic [2:0]    s_axi_arsize,
  input  logic [1:0]    s_axi_arburst,
  input  logic          s_axi_arvalid,
  output logic          s_axi_arready,
  output logic [63:0]   s_axi_rdata,
  output logic [1:0]    s_axi_rresp,
  output logic          s_axi_rlast,
  output logic          s_axi_rvalid,
  input  logic          s_axi_rready,
  input  logic          load_we,
  input  logic [AW-1:0] load_addr,
  input  logic [63:0]   load_data,
  output logic          busy
);

  localparam int unsigned LW = (FIRST_BEAT_LAT > 1) ? $clog2(FIRST_BEAT_LAT) : 1;

  logic [63:0] mem [MEM_WORDS];

  rsp_state_e  state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  burst_q, burst_d;
  logic        err_q, err_d;
  logic [7:0]  beat_q, beat_d;
  logic [LW-1:0] lat_q, lat_d;

  logic        arready_d, rvalid_d, rlast_d, busy_d;
  logic [63:0] rdata_d;
  logic [1:0]  rresp_d;

  logic [63:0] gen_addr, next_addr;
  logic [7:0]  gen_len;
  logic [2:0]  gen_size;
  logic [1:0]  gen_burst;
  logic        legal;

  logic [63:0] fetch_addr, word_idx, fetch_data;
  logic [1:0]  fetch_resp;
  logic        in_range;

  // Address generator sees the incoming request while idle (for the legality
  // check) and the latched burst otherwise (for beat advance).
  always_comb begin
    if (state_q == IDLE) begin
      gen_addr  = s_axi_araddr;
      gen_len   = s_axi_arlen;
      gen_size  = s_axi_arsize;
      gen_burst = s_axi_arburst;
    end else begin
      gen_addr  = addr_q;
      gen_len   = len_q;
      gen_size  = size_q;
      gen_burst = burst_q;
    end
  end

  axi_burst_addr_gen u_addr_gen (
    .addr      (gen_addr),
    .len       (gen_len),
    .size      (gen_size),
    .burst     (gen_burst),
    .next_addr (next_addr),
    .legal     (legal)
  );

  // Beat fetch: beat 0 comes from the latched start address, later beats
  // from the advanced address.
  always_comb begin
    fetch_addr = (state_q == WAIT) ? addr_q : next_addr;
    word_idx   = (fetch_addr - BASE_ADDR) >> 3;
    in_range   = (fetch_addr >= BASE_ADDR) && (word_idx < 64'(MEM_WORDS));
    if (err_q || !in_range) begin
      fetch_data = '0;
      fetch_resp = SLVERR;
    end else begin
      fetch_data = mem[word_idx[AW-1:0]];
      fetch_resp = OKAY;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    err_d     = err_q;
    beat_d    = beat_q;
    lat_d     = lat_q;
    arready_d = s_axi_arready;
    rvalid_d  = s_axi_rvalid;
    rlast_d   = s_axi_rlast;
    rdata_d   = s_axi_rdata;
    rresp_d   = s_axi_rresp;

    case (state_q)
      IDLE: begin
        arready_d = 1'b1;
        rvalid_d  = 1'b0;
        if (s_axi_arvalid && s_axi_arready) begin
          addr_d    = s_axi_araddr;
          len_d     = s_axi_arlen;
          size_d    = s_axi_arsize;
          burst_d   = s_axi_arburst;
          err_d     = !legal;
          beat_d    = '0;
          lat_d     = LW'(FIRST_BEAT_LAT - 1);
          arready_d = 1'b0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (lat_q == '0) begin
          state_d  = BURST;
          rvalid_d = 1'b1;
          rdata_d  = fetch_data;
          rresp_d  = fetch_resp;
          rlast_d  = (len_q == 8'd0);
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      BURST: begin
        if (s_axi_rvalid && s_axi_rready) begin
          if (beat_q == len_q) begin
            state_d   = IDLE;
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
          end else begin
            addr_d  = next_addr;
            beat_d  = beat_q + 8'd1;
            rdata_d = fetch_data;
            rresp_d = fetch_resp;
            rlast_d = ((beat_q + 8'd1) == len_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      len_q         <= '0;
      size_q        <= '0;
      burst_q       <= '0;
      err_q         <= 1'b0;
      beat_q        <= '0;
      lat_q         <= '0;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= '0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      size_q        <= size_d;
      burst_q       <= burst_d;
      err_q         <= err_d;
      beat_q        <= beat_d;
      lat_q         <= lat_d;
      s_axi_arready <= arready_d;
      s_axi_rvalid  <= rvalid_d;
      s_axi_rlast   <= rlast_d;
      s_axi_rdata   <= rdata_d;
      s_axi_rresp   <= rresp_d;
      busy          <= busy_d;
    end
  end

  // Memory survives reset so preloaded images are kept.
  always_ff @(posedge clk) begin
    if (load_we) begin
      mem[load_addr] <= load_data;
    end
  end

endmodule

// File: tb/tb_axi_rd_responder.sv
module tb_axi_rd_responder;

  localparam logic [63:0] BASE = 64'h0;
  localparam int unsigned WORDS = 1024;
  localparam int unsigned LAT = 2;

  logic        clk;
  logic        reset;
  logic [63:0] s_axi_araddr;
  logic [7:0]  s_axi_arlen;
  logic [2:0]  s_axi_arsize;
  logic [1:0]  s_axi_arburst;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [63:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic        load_we;
  logic [9:0]  load_addr;
  logic [63:0] load_data;
  logic        busy;

  axi_rd_responder #(
    .BASE_ADDR      (BASE),
    .MEM_WORDS      (WORDS),
    .FIRST_BEAT_LAT (LAT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arlen   (s_axi_arlen),
    .s_axi_arsize  (s_axi_arsize),
    .s_axi_arburst (s_axi_arburst),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rlast   (s_axi_rlast),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .load_we       (load_we),
    .load_addr     (load_addr),
    .load_data     (load_data),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  int n_cmp = 0;
  int n_fail = 0;

  logic [63:0] mdl_mem [WORDS];
  beat_t expq[$];
  beat_t got[$];
  int  m_phase = 0;       // 0 idle, 1 waiting for first beat, 2 streaming
  int  lat_left = 0;
  bit  exp_arready = 1'b0;
  bit  in_rst = 1'b1;
  int  bursts_done = 0;
  int  ars_issued = 0;
  int  rmode = 0;
  int  pi = 0;

  bit          have_edge = 1'b0;
  bit          p_rst, p_ar, p_r;
  logic [63:0] p_addr;
  logic [7:0]  p_len;
  logic [2:0]  p_size;
  logic [1:0]  p_burst;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected beat list derived directly from the burst rules.
  function automatic void build(input logic [63:0] addr, input logic [7:0] len,
                                input logic [2:0] size, input logic [1:0] burst);
    logic [63:0] a, bytes, total, wbase;
    bit bad;
    beat_t b;
    bad = (size > 3) || (burst == 2'd3) ||
          (burst == 2'd2 && !(len == 1 || len == 3 || len == 7 || len == 15));
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      b.last = (i == int'(len));
      if (bad || a < BASE || ((a - BASE) / 8) >= 64'(WORDS)) begin
        b.data = '0;
        b.resp = 2'b10;
      end else begin
        b.data = mdl_mem[(a - BASE) / 8];
        b.resp = 2'b00;
      end
      expq.push_back(b);
      if (!bad) begin
        bytes = 64'd1 << size;
        if (burst == 2'd1) begin
          a = (a / bytes) * bytes + bytes;
        end else if (burst == 2'd2) begin
          total = bytes * (64'(len) + 64'd1);
          wbase = (a / total) * total;
          a = wbase + ((a - wbase + bytes) % total);
        end
      end
    end
  endfunction

  // Model step for the edge just passed, compare, then observe the next edge.
  always @(negedge clk) begin
    if (have_edge) begin
      if (p_rst) begin
        if (m_phase != 0) bursts_done++;
        m_phase = 0;
        expq.delete();
        exp_arready = 1'b0;
        in_rst = 1'b1;
      end else begin
        in_rst = 1'b0;
        case (m_phase)
          0: begin
            if (p_ar) begin
              build(p_addr, p_len, p_size, p_burst);
              m_phase = 1;
              lat_left = LAT;
              exp_arready = 1'b0;
            end else begin
              exp_arready = 1'b1;
            end
          end
          1: begin
            lat_left--;
            if (lat_left == 0) m_phase = 2;
          end
          default: begin
            if (p_r) begin
              void'(expq.pop_front());
              if (expq.size() == 0) begin
                m_phase = 0;
                exp_arready = 1'b1;
                bursts_done++;
              end
            end
          end
        endcase
      end
      chk("arready", 64'(s_axi_arready), 64'(exp_arready));
      chk("busy",    64'(busy),          64'(m_phase != 0));
      chk("rvalid",  64'(s_axi_rvalid),  64'(m_phase == 2));
      if (in_rst) begin
        chk("rst_rdata", s_axi_rdata,        64'd0);
        chk("rst_rresp", 64'(s_axi_rresp),   64'd0);
        chk("rst_rlast", 64'(s_axi_rlast),   64'd0);
      end
      if (m_phase == 2 && expq.size() > 0) begin
        chk("rdata", s_axi_rdata,      expq[0].data);
        chk("rresp", 64'(s_axi_rresp), 64'(expq[0].resp));
        chk("rlast", 64'(s_axi_rlast), 64'(expq[0].last));
      end
    end
    p_rst   = !reset;
    p_ar    = s_axi_arvalid && s_axi_arready;
    p_r     = s_axi_rvalid && s_axi_rready;
    p_addr  = s_axi_araddr;
    p_len   = s_axi_arlen;
    p_size  = s_axi_arsize;
    p_burst = s_axi_arburst;
    if (p_r && reset) begin
      got.push_back('{data: s_axi_rdata, resp: s_axi_rresp, last: s_axi_rlast});
    end
    have_edge = 1'b1;
  end

  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  always @(posedge clk) begin
    #1;
    case (rmode)
      0: s_axi_rready = 1'b1;
      1: begin s_axi_rready = pat[pi]; pi = (pi + 1) % 4; end
      default: s_axi_rready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic load_word(input int idx, input logic [63:0] d);
    load_we = 1'b1;
    load_addr = 10'(idx);
    load_data = d;
    mdl_mem[idx] = d;
    @(posedge clk); #1;
    load_we = 1'b0;
  endtask

  task automatic ar(input logic [63:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
    bit ok;
    ok = 1'b0;
    s_axi_araddr = a; s_axi_arlen = l; s_axi_arsize = s; s_axi_arburst = b;
    s_axi_arvalid = 1'b1;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge clk);
      if (s_axi_arready) ok = 1'b1;
    end
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    if (ok) ars_issued++;
    else begin
      n_cmp++; n_fail++;
      $display("FAIL ar_timeout: arready never seen, expected 1 at %0t", $time);
    end
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(posedge clk); #1;
      if (bursts_done >= ars_issued) ok = 1'b1;
    end
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL burst_timeout: done %0d expected %0d", bursts_done, ars_issued);
    end
  endtask

  task automatic wait_got(input int n);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(posedge clk); #1;
      if (got.size() >= n) ok = 1'b1;
    end
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL beat_timeout: beats %0d expected %0d", got.size(), n);
    end
  endtask

  task automatic check_got(input string nm, input int idx, input logic [63:0] d,
                           input logic [1:0] r, input logic l);
    if (idx >= got.size()) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: beat %0d missing, got %0d beats", nm, idx, got.size());
    end else begin
      chk({nm, "_data"}, got[idx].data, d);
      chk({nm, "_resp"}, 64'(got[idx].resp), 64'(r));
      chk({nm, "_last"}, 64'(got[idx].last), 64'(l));
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ra;
    logic [7:0]  rl;
    logic [2:0]  rs;
    logic [1:0]  rb;
    int          sel;
    reset = 1'b0;
    s_axi_arvalid = 1'b0;
    s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0; s_axi_arburst = '0;
    load_we = 1'b0; load_addr = '0; load_data = '0;
    for (int i = 0; i < int'(WORDS); i++) mdl_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < int'(WORDS); i++) load_word(i, 64'h0);
    reset = 1'b1;

    // Incrementing burst of 8 full words
    for (int i = 0; i < 8; i++) load_word(i, 64'h1000 + 64'(i));
    got.delete();
    ar(64'h0, 8'd7, 3'd3, 2'd1);
    wait_done();
    chk("t1_count", 64'(got.size()), 64'd8);
    for (int i = 0; i < 8; i++) check_got("t1", i, 64'h1000 + 64'(i), 2'b00, i == 7);

    // Wrapping burst of 4 starting at word 2
    got.delete();
    ar(64'h10, 8'd3, 3'd3, 2'd2);
    wait_done();
    check_got("t2_b0", 0, 64'h1002, 2'b00, 1'b0);
    check_got("t2_b1", 1, 64'h1003, 2'b00, 1'b0);
    check_got("t2_b2", 2, 64'h1000, 2'b00, 1'b0);
    check_got("t2_b3", 3, 64'h1001, 2'b00, 1'b1);

    // Backpressure pattern 1,0,0,1
    rmode = 1; pi = 0;
    got.delete();
    ar(64'h0, 8'd7, 3'd3, 2'd1);
    wait_done();
    chk("t3_count", 64'(got.size()), 64'd8);
    for (int i = 0; i < 8; i++) check_got("t3", i, 64'h1000 + 64'(i), 2'b00, i == 7);
    rmode = 0;

    // Oversized beat: whole burst errors, then a legal burst is fine
    got.delete();
    ar(64'h0, 8'd7, 3'd4, 2'd1);
    wait_done();
    chk("t4_count", 64'(got.size()), 64'd8);
    check_got("t4_b0", 0, 64'h0, 2'b10, 1'b0);
    check_got("t4_b7", 7, 64'h0, 2'b10, 1'b1);
    got.delete();
    ar(64'h8, 8'd0, 3'd3, 2'd1);
    wait_done();
    check_got("t4_ok", 0, 64'h1001, 2'b00, 1'b1);

    // Burst running off the top of memory
    load_word(1023, 64'hABCD_0000_0000_1234);
    got.delete();
    ar(64'h1FF8, 8'd1, 3'd3, 2'd1);
    wait_done();
    check_got("t5_b0", 0, 64'hABCD_0000_0000_1234, 2'b00, 1'b0);
    check_got("t5_b1", 1, 64'h0, 2'b10, 1'b1);

    // Reset during beat 3, then a fresh burst
    got.delete();
    ar(64'h0, 8'd7, 3'd3, 2'd1);
    wait_got(3);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    wait_done();
    got.delete();
    ar(64'h0, 8'd1, 3'd3, 2'd1);
    wait_done();
    check_got("t6_first", 0, 64'h1000, 2'b00, 1'b0);

    // Randomized bursts with random backpressure and idle-time loads
    rmode = 2;
    for (int it = 0; it < 150; it++) begin
      wait_done();
      for (int k = 0; k < int'($urandom_range(0, 3)); k++)
        load_word(int'($urandom_range(0, WORDS - 1)), {$urandom, $urandom});
      for (int n = 0; n < ($urandom_range(0, 3) == 0 ? 2 : 1); n++) begin
        sel = int'($urandom_range(0, 9));
        if (sel < 8)       ra = 64'($urandom_range(0, 8 * WORDS - 1));
        else if (sel == 8) ra = 64'($urandom_range(8 * WORDS - 64, 8 * WORDS + 64));
        else               ra = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) rl = 8'($urandom_range(0, 40));
        else begin
          sel = int'($urandom_range(0, 4));
          rl = (sel == 0) ? 8'd0 : 8'((1 << sel) - 1);
        end
        rs = ($urandom_range(0, 8) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
        rb = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        ar(ra, rl, rs, rb);
      end
    end
    wait_done();
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_rd_responder.md
# axi_rd_responder

AXI4 read-channel responder (slave side) backed by a local 64-bit word memory; serves AR/R burst requests from the instruction-fetch master and from any other read initiator in the core. It accepts one burst at a time, streams beats with full `rready` backpressure, and flags illegal or out-of-range accesses with `SLVERR`. A side load port preloads program images before or during simulation.

## Interface
- `BASE_ADDR`, 64'h0, byte address of memory word 0
- `MEM_WORDS`, 1024, memory depth in 64-bit words; power of two
- `FIRST_BEAT_LAT`, 2, cycles from AR handshake to first `rvalid`; must be ≥1
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-low
- `s_axi_araddr`  in  64  burst start byte address
- `s_axi_arlen`  in  8  beats minus one
- `s_axi_arsize`  in  3  log2 bytes per beat
- `s_axi_arburst`  in  2  FIXED=0, INCR=1, WRAP=2
- `s_axi_arvalid`  in  1  request valid
- `s_axi_arready`  out  1  request accepted
- `s_axi_rdata`  out  64  beat data
- `s_axi_rresp`  out  2  OKAY=0, SLVERR=2
- `s_axi_rlast`  out  1  final beat of burst
- `s_axi_rvalid`  out  1  beat valid
- `s_axi_rready`  in  1  master accepts beat
- `load_we`  in  1  memory write strobe
- `load_addr`  in  $clog2(MEM_WORDS)  word index
- `load_data`  in  64  word to write
- `busy`  out  1  burst in progress (state ≠ IDLE)

## Operation
- States: IDLE → WAIT → BURST → IDLE.
- IDLE: `arready`=1. On `arvalid&&arready`, latch addr/len/size/burst, clear beat counter, load latency counter; go to WAIT.
- WAIT: count down `FIRST_BEAT_LAT-1` cycles; enter BURST with beat 0 fetched.
- BURST: `rvalid`=1. `rdata`/`rresp`/`rlast` are captured when a beat is presented and held stable until `rvalid&&rready`. On handshake: if beat==len, go to IDLE; otherwise advance address and present the next beat the following cycle.
- `rdata` is always the full aligned word at `addr[..:3]`; narrow sizes do not shift lanes.
- Next address, with bytes = 1<<size:
  - FIXED: unchanged.
  - INCR: `(addr & ~(bytes-1)) + bytes`.
  - WRAP: total = bytes*(len+1); `(addr & ~(total-1)) | ((addr+bytes) & (total-1))`.
- Whole-burst error (every beat SLVERR, `rdata`=0, burst still runs len+1 beats with correct `rlast`):
  - size>3
  - arburst=3
  - WRAP with len ∉ {1,3,7,15}
- Per-beat error: `addr<BASE_ADDR` or `(addr-BASE_ADDR)>>3 ≥ MEM_WORDS` gives SLVERR with `rdata`=0.
- Load port: written word is visible to beats captured from the next cycle on. A beat already presented is not altered. Loads are legal in any state.
- Reset (`reset`=0): state IDLE. `arready`, `rvalid`, `rlast`, `busy`, `rresp`, `rdata` all 0. Memory contents are not cleared.
- Reset mid-burst abandons the burst; `rvalid`=0 from the next edge.

## Timing
- All outputs are registered.
- First cycle after reset release: `arready`=1.
- AR handshake at edge T: `arready`=0 from T; first `rvalid` after T+`FIRST_BEAT_LAT`.
- With `rready` held high: one beat per cycle, len+1 consecutive cycles.
- Last beat accepted at edge L: `rvalid`=0 and `arready`=1 after L.
- Minimum turnaround between bursts is 1 idle cycle.
- `arvalid` while busy is ignored (`arready`=0); the master must hold the request.

## Structure
- `axi_pkg`: burst enum (FIXED/INCR/WRAP), resp constants (OKAY/SLVERR), responder state enum.
- Sub-module `axi_burst_addr_gen`: combinational next-address and burst-legality check from addr/len/size/burst.
- Memory array, FSM and beat registers live in the top block.

## Test plan
- Preload words 0–7 = 0x1000+i. AR addr 0, len 7, size 3, INCR, `rready`=1, LAT=2 → `rvalid` 2 cycles after handshake; 8 consecutive beats 0x1000..0x1007; `rlast` only on beat 7; all OKAY.
- AR addr 0x10, len 3, size 3, WRAP → words 2,3,0,1; `rlast` on word 1.
- Same as first test with `rready` toggling 1,0,0,1 → `rdata`/`rlast` stable during stalls; no beat lost or duplicated; 8 beats total.
- AR size=3'b100, len 7 → 8 beats SLVERR, `rdata`=0, `rlast` on 8th; then legal burst served OKAY.
- AR addr 0x1FF8, len 1, INCR, MEM_WORDS=1024 → beat 0 OKAY with word 1023; beat 1 SLVERR with 0.
- Assert `reset` during beat 3 → `rvalid`=0 next cycle. After release `arready`=1; new burst addr 0 returns 0x1000 first.
